bsg_cache_sbuf_drain: RTL and testbench

Drains the cache store buffer into the data memory, one masked write per entry. It pops entries through the buffer's valid/yumi output, holds one entry, and writes it to the data SRAM when the tag/load pipeline is not using the port. It merges an incoming entry into the held one when both target the same way and word. It bounds write starvation by stalling the pipeline.

---
 rtl/bsg_cache_sbuf_drain.sv | 151 +++++++++++++++
 tb/tb_bsg_cache_sbuf_drain.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_sbuf_drain.sv
// bsg_cache_sbuf_drain
//   Drains store-buffer entries into the data SRAM, one masked write per held
//   entry. One entry is held at a time. It is written whenever the tag/load
//   pipeline leaves the port free. A same-way, same-word follower is merged
//   into it while it waits. After starve_limit_p blocked cycles, the block
//   stalls the pipeline for one cycle and forces the write.
//
// Ports
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   sbuf_entry_i       {addr, data, byte mask, way id}
//   sbuf_v_i           store buffer offers an entry
//   sbuf_yumi_o        entry consumed this cycle
//   pipe_req_i         pipeline wants the data-memory port this cycle
//   stall_pipe_o       pipeline must not issue (registered)
//   dm_v_o             data-memory write strobe
//   dm_way_o/addr_o/data_o/mask_o  held entry fields (word address)
//   drained_o          nothing held and nothing pending
//   state_o            debug view of the FSM state
//
// Handshake: sbuf_v_i/sbuf_yumi_o follow valid/yumi semantics. The entry
// counts as transferred in any cycle where both are high. sbuf_yumi_o may
// depend combinationally on sbuf_v_i, sbuf_entry_i and pipe_req_i.
module bsg_cache_sbuf_drain #(
  parameter int addr_width_p   = 39,
  parameter int data_width_p   = 64,
  parameter int ways_p         = 8,
  parameter int starve_limit_p = 4,
  localparam int MASK_W  = data_width_p / 8,
  localparam int WAY_W   = $clog2(ways_p),
  localparam int OFF_W   = $clog2(MASK_W),
  localparam int WORD_W  = addr_width_p - OFF_W,
  localparam int ENTRY_W = addr_width_p + data_width_p + MASK_W + WAY_W
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [ENTRY_W-1:0]      sbuf_entry_i,
  input  logic                    sbuf_v_i,
  output logic                    sbuf_yumi_o,
  input  logic                    pipe_req_i,
  output logic                    stall_pipe_o,
  output logic                    dm_v_o,
  output logic [WAY_W-1:0]        dm_way_o,
  output logic [WORD_W-1:0]       dm_addr_o,
  output logic [data_width_p-1:0] dm_data_o,
  output logic [MASK_W-1:0]       dm_mask_o,
  output logic                    drained_o,
  output logic [1:0]              state_o
);

  localparam int CNT_W = $clog2(starve_limit_p) + 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PEND  = 2'd1,
    S_FORCE = 2'd2
  } state_e;

  state_e state_q, state_n;
  logic [CNT_W-1:0]        cnt_q, cnt_n;
  logic [WAY_W-1:0]        way_q;
  logic [WORD_W-1:0]       word_q;
  logic [data_width_p-1:0] data_q;
  logic [MASK_W-1:0]       mask_q;

  // Entry fields. The byte offset inside the word is not needed because
  // writes are whole-word with a byte mask.
  logic [WORD_W-1:0]       e_word;
  logic [data_width_p-1:0] e_data;
  logic [MASK_W-1:0]       e_mask;
  logic [WAY_W-1:0]        e_way;
  logic [OFF_W-1:0]        unused_e_offset;

  assign e_word          = sbuf_entry_i[ENTRY_W-1 -: WORD_W];
  assign unused_e_offset = sbuf_entry_i[data_width_p+MASK_W+WAY_W +: OFF_W];
  assign e_data          = sbuf_entry_i[MASK_W+WAY_W +: data_width_p];
  assign e_mask          = sbuf_entry_i[WAY_W +: MASK_W];
  assign e_way           = sbuf_entry_i[WAY_W-1:0];

  logic hold_v, grant, coalesce, load;

  assign hold_v   = (state_q != S_EMPTY);
  // The pipeline wins the port except in FORCE. In FORCE it is stalled, so
  // pipe_req_i is ignored.
  assign grant    = hold_v & (~pipe_req_i | (state_q == S_FORCE));
  // Merging is only allowed while the held entry waits. On a grant, the held
  // entry is written and a same-word follower is loaded separately.
  assign coalesce = hold_v & ~grant & sbuf_v_i & (e_way == way_q) & (e_word == word_q);
  assign sbuf_yumi_o = sbuf_v_i & (~hold_v | grant | coalesce);
  assign load     = sbuf_yumi_o & ~coalesce;

  assign dm_v_o       = grant;
  assign dm_way_o     = way_q;
  assign dm_addr_o    = word_q;
  assign dm_data_o    = data_q;
  assign dm_mask_o    = mask_q;
  assign stall_pipe_o = (state_q == S_FORCE);
  assign drained_o    = ~hold_v & ~sbuf_v_i;
  assign state_o      = state_q;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      S_EMPTY: begin
        if (load) state_n = S_PEND;
      end
      S_PEND: begin
        if (grant) begin
          state_n = load ? S_PEND : S_EMPTY;
        end else begin
          // The compare uses the count before increment. A write popped at t
          // is therefore blocked t+1..t+starve_limit_p and forced one cycle
          // later.
          cnt_n = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(starve_limit_p - 1)) state_n = S_FORCE;
        end
      end
      S_FORCE: begin
        state_n = load ? S_PEND : S_EMPTY;
      end
      default: state_n = S_EMPTY;
    endcase
    if (load) cnt_n = '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      way_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (load) begin
        way_q  <= e_way;
        word_q <= e_word;
        data_q <= e_data;
        mask_q <= e_mask;
      end else if (coalesce) begin
        for (int i = 0; i < MASK_W; i++) begin
          if (e_mask[i]) data_q[i*8 +: 8] <= e_data[i*8 +: 8];
        end
        mask_q <= mask_q | e_mask;
      end
    end
  end

endmodule

// File: tb/tb_bsg_cache_sbuf_drain.sv
// Directed testbench for bsg_cache_sbuf_drain (default parameters).
// Inputs are applied 1 ns after a rising edge. Outputs are checked 2 ns later,
// well before the next rising edge.
module tb_bsg_cache_sbuf_drain;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [113:0] sbuf_entry_i;
  logic         sbuf_v_i;
  logic         sbuf_yumi_o;
  logic         pipe_req_i;
  logic         stall_pipe_o;
  logic         dm_v_o;
  logic [2:0]   dm_way_o;
  logic [35:0]  dm_addr_o;
  logic [63:0]  dm_data_o;
  logic [7:0]   dm_mask_o;
  logic         drained_o;
  logic [1:0]   state_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  // clock / reset
  always #5 clk_i = ~clk_i;

  bsg_cache_sbuf_drain dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .sbuf_entry_i (sbuf_entry_i),
    .sbuf_v_i     (sbuf_v_i),
    .sbuf_yumi_o  (sbuf_yumi_o),
    .pipe_req_i   (pipe_req_i),
    .stall_pipe_o (stall_pipe_o),
    .dm_v_o       (dm_v_o),
    .dm_way_o     (dm_way_o),
    .dm_addr_o    (dm_addr_o),
    .dm_data_o    (dm_data_o),
    .dm_mask_o    (dm_mask_o),
    .drained_o    (drained_o),
    .state_o      (state_o)
  );

  // driver helpers
  function automatic logic [113:0] mk(input logic [38:0] addr, input logic [63:0] data,
                                      input logic [7:0] mask, input logic [2:0] way);
    return {addr, data, mask, way};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic [113:0] e, input logic req);
    sbuf_v_i     = v;
    sbuf_entry_i = e;
    pipe_req_i   = req;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n_i = 1'b0;
    drive(1'b0, '0, 1'b0);
    settle();
    // reset state
    check("rst_dm_v", 64'(dm_v_o), 64'd0);
    check("rst_stall", 64'(stall_pipe_o), 64'd0);
    check("rst_state", 64'(state_o), 64'(ST_EMPTY));
    check("rst_addr", 64'(dm_addr_o), 64'd0);
    check("rst_drained", 64'(drained_o), 64'd1);
    check("rst_yumi_idle", 64'(sbuf_yumi_o), 64'd0);
    sbuf_v_i = 1'b1;
    settle();
    check("rst_yumi_v", 64'(sbuf_yumi_o), 64'd1);
    check("rst_drained_v", 64'(drained_o), 64'd0);
    tick();
    check("rst_still_empty", 64'(state_o), 64'(ST_EMPTY));
    drive(1'b0, '0, 1'b0);
    reset_n_i = 1'b1;
    tick();

    // streaming: three back-to-back entries, port always free
    drive(1'b1, mk(39'h100, 64'hD0D0_0000_0000_0001, 8'hFF, 3'd1), 1'b0);
    settle();
    check("str0_yumi", 64'(sbuf_yumi_o), 64'd1);
    check("str0_dm_v", 64'(dm_v_o), 64'd0);
    tick();
    drive(1'b1, mk(39'h108, 64'hD0D0_0000_0000_0002, 8'hFF, 3'd1), 1'b0);
    settle();
    check("str1_yumi", 64'(sbuf_yumi_o), 64'd1);
    check("str1_dm_v", 64'(dm_v_o), 64'd1);
    check("str1_addr", 64'(dm_addr_o), 64'h20);
    check("str1_data", dm_data_o, 64'hD0D0_0000_0000_0001);
    tick();
    drive(1'b1, mk(39'h110, 64'hD0D0_0000_0000_0003, 8'hFF, 3'd1), 1'b0);
    settle();
    check("str2_yumi", 64'(sbuf_yumi_o), 64'd1);
    check("str2_dm_v", 64'(dm_v_o), 64'd1);
    check("str2_addr", 64'(dm_addr_o), 64'h21);
    tick();
    drive(1'b0, '0, 1'b0);
    settle();
    check("str3_dm_v", 64'(dm_v_o), 64'd1);
    check("str3_addr", 64'(dm_addr_o), 64'h22);
    check("str3_yumi", 64'(sbuf_yumi_o), 64'd0);
    tick();
    check("str4_dm_v", 64'(dm_v_o), 64'd0);
    check("str4_drained", 64'(drained_o), 64'd1);

    // coalesce: two halves of one word merge while the port is busy
    drive(1'b1, mk(39'h200, 64'h0000_0000_1122_3344, 8'h0F, 3'd2), 1'b1);
    settle();
    check("co0_yumi", 64'(sbuf_yumi_o), 64'd1);
    tick();
    drive(1'b1, mk(39'h204, 64'hAABB_CCDD_0000_0000, 8'hF0, 3'd2), 1'b1);
    settle();
    check("co1_yumi", 64'(sbuf_yumi_o), 64'd1);
    check("co1_dm_v", 64'(dm_v_o), 64'd0);
    tick();
    drive(1'b0, '0, 1'b0);
    settle();
    check("co2_dm_v", 64'(dm_v_o), 64'd1);
    check("co2_mask", 64'(dm_mask_o), 64'hFF);
    check("co2_data", dm_data_o, 64'hAABB_CCDD_1122_3344);
    check("co2_addr", 64'(dm_addr_o), 64'h40);
    check("co2_way", 64'(dm_way_o), 64'd2);
    tick();
    check("co3_dm_v", 64'(dm_v_o), 64'd0);
    check("co3_state", 64'(state_o), 64'(ST_EMPTY));

    // no coalesce across ways
    drive(1'b1, mk(39'h300, 64'h1111_1111_1111_1111, 8'hFF, 3'd2), 1'b1);
    tick();
    drive(1'b1, mk(39'h300, 64'h5555_5555_5555_5555, 8'hFF, 3'd5), 1'b1);
    settle();
    check("way0_yumi", 64'(sbuf_yumi_o), 64'd0);
    tick();
    settle();
    check("way1_yumi", 64'(sbuf_yumi_o), 64'd0);
    check("way1_dm_v", 64'(dm_v_o), 64'd0);
    tick();
    pipe_req_i = 1'b0;
    settle();
    check("way2_dm_v", 64'(dm_v_o), 64'd1);
    check("way2_way", 64'(dm_way_o), 64'd2);
    check("way2_yumi", 64'(sbuf_yumi_o), 64'd1);
    tick();
    drive(1'b0, '0, 1'b0);
    settle();
    check("way3_dm_v", 64'(dm_v_o), 64'd1);
    check("way3_way", 64'(dm_way_o), 64'd5);
    check("way3_data", dm_data_o, 64'h5555_5555_5555_5555);
    tick();

    // starvation, then FORCE with a follow-on entry
    drive(1'b1, mk(39'h400, 64'h4444_0000_0000_0000, 8'hFF, 3'd0), 1'b1);
    tick();                                  // t+1
    drive(1'b0, '0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      settle();
      check($sformatf("stv_t%0d_stall", k), 64'(stall_pipe_o), 64'd0);
      check($sformatf("stv_t%0d_dm_v", k), 64'(dm_v_o), 64'd0);
      tick();
    end
    // t+5: forced write; a new entry pops in the same cycle
    drive(1'b1, mk(39'h408, 64'h8888_0000_0000_0000, 8'hFF, 3'd0), 1'b1);
    settle();
    check("stv_t5_stall", 64'(stall_pipe_o), 64'd1);
    check("stv_t5_dm_v", 64'(dm_v_o), 64'd1);
    check("stv_t5_addr", 64'(dm_addr_o), 64'h80);
    check("stv_t5_yumi", 64'(sbuf_yumi_o), 64'd1);
    tick();                                  // t+6
    drive(1'b0, '0, 1'b1);
    settle();
    check("frc_t6_state", 64'(state_o), 64'(ST_PEND));
    check("frc_t6_stall", 64'(stall_pipe_o), 64'd0);
    check("frc_t6_addr", 64'(dm_addr_o), 64'h81);
    // A cleared counter means four more blocked cycles (t+6..t+9).
    tick(); tick(); tick();                  // t+9
    settle();
    check("frc_t9_stall", 64'(stall_pipe_o), 64'd0);
    tick();                                  // t+10
    settle();
    check("frc_t10_stall", 64'(stall_pipe_o), 64'd1);
    check("frc_t10_dm_v", 64'(dm_v_o), 64'd1);
    tick();                                  // t+11
    settle();
    check("frc_t11_state", 64'(state_o), 64'(ST_EMPTY));
    check("frc_t11_stall", 64'(stall_pipe_o), 64'd0);
    check("frc_t11_dm_v", 64'(dm_v_o), 64'd0);

    // zero-mask entry is still written
    drive(1'b1, mk(39'h600, 64'h6666_6666_6666_6666, 8'h00, 3'd4), 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    settle();
    check("zm_dm_v", 64'(dm_v_o), 64'd1);
    check("zm_mask", 64'(dm_mask_o), 64'h00);
    check("zm_addr", 64'(dm_addr_o), 64'hC0);
    tick();

    // grant with a same-word follower: two separate writes, no merge
    drive(1'b1, mk(39'h700, 64'h0000_0000_0000_00AA, 8'h01, 3'd3), 1'b0);
    tick();
    drive(1'b1, mk(39'h700, 64'h0000_0000_0000_BB00, 8'h02, 3'd3), 1'b0);
    settle();
    check("gs0_dm_v", 64'(dm_v_o), 64'd1);
    check("gs0_mask", 64'(dm_mask_o), 64'h01);
    check("gs0_yumi", 64'(sbuf_yumi_o), 64'd1);
    tick();
    drive(1'b0, '0, 1'b0);
    settle();
    check("gs1_dm_v", 64'(dm_v_o), 64'd1);
    check("gs1_mask", 64'(dm_mask_o), 64'h02);
    check("gs1_data", dm_data_o, 64'h0000_0000_0000_BB00);
    tick();

    // reset mid-hold while in FORCE
    drive(1'b1, mk(39'h500, 64'h5050_5050_5050_5050, 8'hFF, 3'd6), 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    tick(); tick(); tick(); tick();          // pop + 4 blocked cycles
    settle();
    check("rmh_pre_stall", 64'(stall_pipe_o), 64'd1);
    reset_n_i = 1'b0;
    #1;
    check("rmh_dm_v", 64'(dm_v_o), 64'd0);
    check("rmh_stall", 64'(stall_pipe_o), 64'd0);
    check("rmh_state", 64'(state_o), 64'(ST_EMPTY));
    check("rmh_addr", 64'(dm_addr_o), 64'd0);
    tick();
    reset_n_i  = 1'b1;
    pipe_req_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("rmh_post%0d_dm_v", k), 64'(dm_v_o), 64'd0);
      check($sformatf("rmh_post%0d_drained", k), 64'(drained_o), 64'd1);
      tick();
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
